ex_muldiv: RTL and testbench
============================

# ex_muldiv

Multi-cycle HI/LO unit in the EX stage, alongside the ALU, consuming the same 6-bit FUNCT produced in ID. It executes MULT, MULTU, DIV and DIVU iteratively (one bit per cycle) and holds the pipeline with a stall request until the result is written into the architectural HI/LO registers. It also services MTHI/MTLO writes and presents HI/LO for MFHI/MFLO reads.

## Interface
- No parameters; data width fixed at 32, funct width 6.
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `en`  in  1  EX-stage instruction valid, from ID/EX register
- `funct`  in  6  operation code on the FUNCT bus (MIPS encodings: MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B)
- `operand_1`  in  32  rs value (multiplicand / dividend / MTHI-MTLO source)
- `operand_2`  in  32  rt value (multiplier / divisor)
- `flush`  in  1  pipeline flush; aborts in-flight operation
- `stall_req`  out  1  combinational hold request to pipeline control
- `done`  out  1  registered one-cycle pulse: result just committed to HI/LO
- `hi`  out  32  architectural HI register
- `lo`  out  32  architectural LO register

## Operation
- States: IDLE, MUL, DIV, DONE. Reset: state IDLE, counter 0, `hi`=0, `lo`=0, `done`=0, `stall_req`=0.
- IDLE, `en`=1, `flush`=0:
  - MULT/MULTU -> latch operands, go MUL; DIV/DIVU -> latch operands, go DIV. `stall_req`=1 in this cycle.
  - MTHI -> `hi` <= `operand_1`; MTLO -> `lo` <= `operand_1`; no stall, stay IDLE.
  - Any other funct (incl. MFHI/MFLO, 0x00 NOP) -> no action.
- Signed ops (MULT, DIV): operate on magnitudes (|-2^31| = 0x80000000 as unsigned), fix sign at commit. Product negated (64-bit two's complement) if operand signs differ; quotient negated if signs differ; remainder takes dividend's sign.
- MUL: shift-add, 32 iterations, 64-bit accumulator; commit `hi`=product[63:32], `lo`=product[31:0].
- DIV: restoring division, 32 iterations; commit `lo`=quotient, `hi`=remainder.
- Divisor 0: same latency, commit `lo`=0xFFFFFFFF, `hi`=`operand_1` (raw dividend, no sign fix).
- 5-bit counter increments each busy cycle; at counter 31 commit HI/LO on that edge, go DONE.
- DONE: `done`=1, `stall_req`=0, ignore `en` (stalled instruction still present), go IDLE unconditionally next edge.
- `flush`=1 in any state: go IDLE next edge, HI/LO unchanged, no commit, `stall_req` forced 0 same cycle.
- Reset asserted mid-operation: immediate return to reset values.

## Timing
- `stall_req` = (IDLE & `en` & mul/div funct & !`flush`) | ((MUL|DIV) & !`flush`).
- Accept in cycle T; iterate T+1..T+32; HI/LO updated at edge ending T+32; DONE in T+33. `stall_req` high exactly 33 cycles (T..T+32).
- Next instruction enters EX at T+34; MFHI/MFLO there reads the new value directly from `hi`/`lo`.
- MTHI/MTLO in cycle T visible on `hi`/`lo` from T+1 (back-to-back MTHI then MFHI correct).
- `done` high only in DONE cycle; never asserted for MTHI/MTLO or aborted operations.

## Test plan
- MULT 0xFFFFFFFF × 0x00000002 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE; MULTU same operands -> `hi`=0x00000001, `lo`=0xFFFFFFFE; `stall_req` high 33 cycles, `done` one pulse.
- DIV 0xFFFFFFF9 (-7) / 2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF; DIVU 100 / 7 -> `lo`=14, `hi`=2; DIV 0x80000000 / 0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- DIVU 0x12345678 / 0 -> `lo`=0xFFFFFFFF, `hi`=0x12345678 after 33-cycle stall.
- MTHI 0xDEADBEEF then MTLO 0x0BADF00D on consecutive cycles -> `hi`/`lo` updated next cycle each, `stall_req` never high.
- MULT started, `flush` at 10th busy cycle -> `stall_req` 0 same cycle, IDLE next, `hi`/`lo` keep prior values, no `done`.
- `rst` low at 20th DIV cycle -> `hi`=`lo`=0, `stall_req`=0 immediately; after release new DIVU 9/3 -> `lo`=3, `hi`=0.

Source files
------------

// File: rtl/ex_muldiv.sv
// Iterative HI/LO multiply/divide unit. Latency is 32 busy cycles after accept, with a done pulse on the 33rd.
// stall_req holds the pipeline from accept until commit; flush aborts with no commit.
module ex_muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [5:0]  funct,
    input  logic [31:0] operand_1,
    input  logic [31:0] operand_2,
    input  logic        flush,
    output logic        stall_req,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic [31:0] acc_hi, acc_lo, opnd;
    logic        neg_res, neg_rem, div_zero;

    logic        is_mul, is_div, is_signed, start, last;
    logic        op1_neg, op2_neg;
    logic [31:0] op1_mag, op2_mag;

    assign is_mul    = (funct == F_MULT) || (funct == F_MULTU);
    assign is_div    = (funct == F_DIV)  || (funct == F_DIVU);
    assign is_signed = (funct == F_MULT) || (funct == F_DIV);
    assign start     = (state == S_IDLE) && en && !flush && (is_mul || is_div);
    assign last      = (cnt == 5'd31);

    assign op1_neg = is_signed & operand_1[31];
    assign op2_neg = is_signed & operand_2[31];
    assign op1_mag = op1_neg ? (~operand_1 + 32'd1) : operand_1;
    assign op2_mag = op2_neg ? (~operand_2 + 32'd1) : operand_2;

    // Multiply step: acc_hi is the running upper product, acc_lo shifts the multiplier out LSB-first.
    logic [32:0] mul_sum;
    logic [31:0] mul_hi_nxt, mul_lo_nxt;
    logic [63:0] product, prod_fix;

    assign mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : 33'd0);
    assign mul_hi_nxt = mul_sum[32:1];
    assign mul_lo_nxt = {mul_sum[0], acc_lo[31:1]};
    assign product    = {mul_hi_nxt, mul_lo_nxt};
    assign prod_fix   = neg_res ? (~product + 64'd1) : product;

    // Restoring divide step: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
    logic [32:0] div_sh;
    logic        div_ge;
    logic [31:0] div_hi_nxt, div_lo_nxt, quot_fix, rem_fix;

    assign div_sh     = {acc_hi, acc_lo[31]};
    assign div_ge     = div_sh >= {1'b0, opnd};
    assign div_hi_nxt = div_ge ? (div_sh[31:0] - opnd) : div_sh[31:0];
    assign div_lo_nxt = {acc_lo[30:0], div_ge};
    assign quot_fix   = neg_res ? (~div_lo_nxt + 32'd1) : div_lo_nxt;
    // With a zero divisor the remainder path yields |dividend|; re-applying the dividend sign restores the raw value.
    assign rem_fix    = neg_rem ? (~div_hi_nxt + 32'd1) : div_hi_nxt;

    assign stall_req = rst && !flush &&
                       (start || (state == S_MUL) || (state == S_DIV));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = is_mul ? S_MUL : S_DIV;
            S_MUL,
            S_DIV: begin
                if (flush)     state_nxt = S_IDLE;
                else if (last) state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= 5'd0;
            acc_hi   <= 32'd0;
            acc_lo   <= 32'd0;
            opnd     <= 32'd0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc_hi   <= 32'd0;
                        acc_lo   <= is_mul ? op2_mag : op1_mag;
                        opnd     <= is_mul ? op1_mag : op2_mag;
                        neg_res  <= op1_neg ^ op2_neg;
                        neg_rem  <= op1_neg;
                        div_zero <= (operand_2 == 32'd0);
                        cnt      <= 5'd0;
                    end else if (en && !flush && funct == F_MTHI) begin
                        hi <= operand_1;
                    end else if (en && !flush && funct == F_MTLO) begin
                        lo <= operand_1;
                    end
                end
                S_MUL: begin
                    if (flush) begin
                        cnt <= 5'd0;
                    end else begin
                        cnt    <= cnt + 5'd1;
                        acc_hi <= mul_hi_nxt;
                        acc_lo <= mul_lo_nxt;
                        if (last) begin
                            hi   <= prod_fix[63:32];
                            lo   <= prod_fix[31:0];
                            done <= 1'b1;
                        end
                    end
                end
                S_DIV: begin
                    if (flush) begin
                        cnt <= 5'd0;
                    end else begin
                        cnt    <= cnt + 5'd1;
                        acc_hi <= div_hi_nxt;
                        acc_lo <= div_lo_nxt;
                        if (last) begin
                            hi   <= rem_fix;
                            lo   <= div_zero ? 32'hFFFF_FFFF : quot_fix;
                            done <= 1'b1;
                        end
                    end
                end
                default: cnt <= 5'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: stimulus pushes reference HI/LO results, a monitor checks them on each done pulse.
`timescale 1ns/1ps
module tb_ex_muldiv;

    localparam logic [5:0] F_NOP   = 6'h00;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [5:0]  funct = F_NOP;
    logic [31:0] operand_1 = '0;
    logic [31:0] operand_2 = '0;
    logic        flush = 1'b0;
    logic        stall_req, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    logic [63:0] exp_q[$];

    ex_muldiv dut (
        .clk(clk), .rst(rst), .en(en), .funct(funct),
        .operand_1(operand_1), .operand_2(operand_2), .flush(flush),
        .stall_req(stall_req), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; returns {hi, lo}.
    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, uq, ur;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f)
            F_MULT:  return sa * sb;
            F_MULTU: return ua * ub;
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (f == F_DIV) begin
                    q = sa / sb;
                    r = sa % sb;
                    return {r[31:0], q[31:0]};
                end
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst && done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("hilo_commit", {hi, lo}, e);
            end
        end
    end

    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        int stalls;
        int d0;
        stalls = 0;
        d0 = n_done;
        exp_q.push_back(model(f, a, b));
        @(posedge clk); #1;
        en = 1'b1; funct = f; operand_1 = a; operand_2 = b;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!stall_req) break;
            stalls++;
        end
        @(posedge clk); #1;
        en = 1'b0; funct = F_NOP;
        chk("stall_cycles", 64'(stalls), 64'd33);
        chk("done_pulses", 64'(n_done - d0), 64'd1);
    endtask

    task automatic start_and_wait(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                  input int busy_n);
        // Leaves the bench #1 into busy cycle busy_n (1-based) with the op still stalled.
        @(posedge clk); #1;
        en = 1'b1; funct = f; operand_1 = a; operand_2 = b;
        for (int i = 0; i < busy_n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    logic [5:0]  rf;
    logic [31:0] ra, rb;
    logic [31:0] hi_keep, lo_keep;
    int          d_before;
    int          st_seen;

    initial begin
        #2;
        chk("reset_hi", {32'd0, hi}, 64'd0);
        chk("reset_lo", {32'd0, lo}, 64'd0);
        chk("reset_stall", {63'd0, stall_req}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        run_op(F_MULT,  32'hFFFF_FFFF, 32'h0000_0002);
        run_op(F_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
        run_op(F_DIV,   32'hFFFF_FFF9, 32'h0000_0002);
        run_op(F_DIVU,  32'd100,       32'd7);
        run_op(F_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        run_op(F_DIVU,  32'h1234_5678, 32'd0);
        run_op(F_DIV,   32'hF000_0000, 32'd0);

        // MTHI then MTLO back to back.
        st_seen = 0;
        @(posedge clk); #1;
        en = 1'b1; funct = F_MTHI; operand_1 = 32'hDEAD_BEEF;
        #1; st_seen += int'(stall_req);
        @(posedge clk); #1;
        chk("mthi_next_cycle", {32'd0, hi}, {32'd0, 32'hDEAD_BEEF});
        funct = F_MTLO; operand_1 = 32'h0BAD_F00D;
        #1; st_seen += int'(stall_req);
        @(posedge clk); #1;
        en = 1'b0; funct = F_NOP;
        chk("mtlo_next_cycle", {hi, lo}, {32'hDEAD_BEEF, 32'h0BAD_F00D});
        chk("mt_no_stall", 64'(st_seen), 64'd0);

        // Flush in the 10th busy cycle of a MULT.
        hi_keep = hi; lo_keep = lo; d_before = n_done;
        start_and_wait(F_MULT, 32'h0000_1234, 32'h0000_5678, 10);
        chk("pre_flush_stall", {63'd0, stall_req}, 64'd1);
        flush = 1'b1;
        #1; chk("flush_stall_low", {63'd0, stall_req}, 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; en = 1'b0; funct = F_NOP;
        st_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            st_seen += int'(stall_req);
        end
        chk("flush_idle_after", 64'(st_seen), 64'd0);
        chk("flush_hilo_kept", {hi, lo}, {hi_keep, lo_keep});
        chk("flush_no_done", 64'(n_done - d_before), 64'd0);

        // Async reset in the 20th DIV cycle.
        start_and_wait(F_DIV, 32'h7777_0000, 32'h0000_0013, 20);
        rst = 1'b0; en = 1'b0; funct = F_NOP;
        #1;
        chk("midreset_hilo", {hi, lo}, 64'd0);
        chk("midreset_stall", {63'd0, stall_req}, 64'd0);
        chk("midreset_done", {63'd0, done}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        run_op(F_DIVU, 32'd9, 32'd3);

        // Random operations, mixing in corner operands.
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(3))
                0: rf = F_MULT;
                1: rf = F_MULTU;
                2: rf = F_DIV;
                default: rf = F_DIVU;
            endcase
            ra = $urandom();
            rb = $urandom();
            case ($urandom_range(7))
                0: rb = 32'd0;
                1: ra = 32'h8000_0000;
                2: rb = 32'hFFFF_FFFF;
                3: rb = rb >> $urandom_range(31);
                default: ;
            endcase
            run_op(rf, ra, rb);
        end

        repeat (3) @(posedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
